// File: rtl/bcd_stopwatch_ctr.sv
// Multi-digit BCD up/down stopwatch counter with tick prescaler, wrap/saturate
// terminal handling, parallel load and lap (display freeze) capture.
module bcd_stopwatch_ctr #(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned NUM_DIGITS = 4,
    parameter bit          WRAP       = 1'b1
) (
    input  logic                    clk_5MHz,
    input  logic                    reset,
    input  logic                    start_stop,
    input  logic                    clear,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [4*NUM_DIGITS-1:0] display,
    output logic                    running,
    output logic                    tick,
    output logic                    tc,
    output logic                    lap_hold
);

    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam int unsigned DigW = 4 * NUM_DIGITS;
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic [DigW-1:0] digits_q, digits_d;
    logic [DigW-1:0] snap_q, snap_d;
    logic            running_q, running_d;
    logic            tick_q, tick_d;
    logic            tc_q, tc_d;
    logic            lap_hold_q, lap_hold_d;

    logic [DigW-1:0] stepped;
    logic [DigW-1:0] clamped;
    logic            at_term;
    logic            next_term;

    // Ripple carry/borrow through the digits; a carry out of the top digit
    // means every digit was at the terminal value for this direction.
    always_comb begin : bcd_step
        logic       carry;
        logic [3:0] d;
        carry     = 1'b1;
        d         = 4'd0;
        stepped   = digits_q;
        next_term = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            d = digits_q[4*i +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (d >= 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            stepped[4*i +: 4] = d;
            if (d != (up_dn ? 4'd9 : 4'd0)) begin
                next_term = 1'b0;
            end
        end
        at_term = carry;
    end

    always_comb begin : load_clamp
        clamped = load_val;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin : next_state
        pre_d      = pre_q;
        digits_d   = digits_q;
        snap_d     = snap_q;
        running_d  = running_q ^ start_stop;
        tick_d     = 1'b0;
        tc_d       = 1'b0;
        lap_hold_d = lap_hold_q ^ lap;

        if (clear) begin
            pre_d      = '0;
            digits_d   = '0;
            snap_d     = '0;
            running_d  = 1'b0;
            lap_hold_d = 1'b0;
        end else if (load) begin
            digits_d = clamped;
            pre_d    = '0;
        end else if (running_q) begin
            if (pre_q == PreLast) begin
                pre_d  = '0;
                tick_d = 1'b1;
                if (at_term) begin
                    // Saturating mode holds the terminal value but still flags each step
                    tc_d = 1'b1;
                    if (WRAP) begin
                        digits_d = stepped;
                    end
                end else begin
                    digits_d = stepped;
                    if (!WRAP && next_term) begin
                        tc_d      = 1'b1;
                        running_d = 1'b0;
                    end
                end
            end else begin
                pre_d = pre_q + PreW'(1);
            end
        end

        if (!clear && lap && !lap_hold_q) begin
            snap_d = digits_d;
        end
    end

    always_ff @(posedge clk_5MHz or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            digits_q   <= '0;
            snap_q     <= '0;
            running_q  <= 1'b0;
            tick_q     <= 1'b0;
            tc_q       <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            digits_q   <= digits_d;
            snap_q     <= snap_d;
            running_q  <= running_d;
            tick_q     <= tick_d;
            tc_q       <= tc_d;
            lap_hold_q <= lap_hold_d;
        end
    end

    assign digits   = digits_q;
    assign display  = lap_hold_q ? snap_q : digits_q;
    assign running  = running_q;
    assign tick     = tick_q;
    assign tc       = tc_q;
    assign lap_hold = lap_hold_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctr.sv
// Directed bench: a wrapping and a saturating two-digit counter share stimulus.
module tb_bcd_stopwatch_ctr;

    logic       clk_5MHz = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic       lap;

    logic [7:0] w_digits, w_display, s_digits, s_display;
    logic       w_running, w_tick, w_tc, w_lap_hold;
    logic       s_running, s_tick, s_tc, s_lap_hold;

    int checks = 0;
    int errors = 0;

    always #5 clk_5MHz = ~clk_5MHz;

    bcd_stopwatch_ctr #(.TICK_DIV(4), .NUM_DIGITS(2), .WRAP(1'b1)) dut_w (
        .clk_5MHz   (clk_5MHz),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .lap        (lap),
        .digits     (w_digits),
        .display    (w_display),
        .running    (w_running),
        .tick       (w_tick),
        .tc         (w_tc),
        .lap_hold   (w_lap_hold)
    );

    bcd_stopwatch_ctr #(.TICK_DIV(4), .NUM_DIGITS(2), .WRAP(1'b0)) dut_s (
        .clk_5MHz   (clk_5MHz),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .lap        (lap),
        .digits     (s_digits),
        .display    (s_display),
        .running    (s_running),
        .tick       (s_tick),
        .tc         (s_tc),
        .lap_hold   (s_lap_hold)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_5MHz);
            #1;
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        cyc(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        up_dn      = 1'b1;
        load       = 1'b0;
        load_val   = 8'h00;
        lap        = 1'b0;
        cyc(2);
        chk("rst_digits", w_digits, 8'h00);
        chk("rst_display", w_display, 8'h00);
        chk("rst_running", w_running, 1'b0);
        chk("rst_tick", w_tick, 1'b0);
        chk("rst_tc", w_tc, 1'b0);
        chk("rst_lap_hold", w_lap_hold, 1'b0);
        reset = 1'b0;
        cyc(1);

        // Start and count at 4-cycle spacing
        pulse_ss();
        chk("t1_running", w_running, 1'b1);
        chk("t1_digits0", w_digits, 8'h00);
        cyc(3);
        chk("t1_no_tick_early", w_tick, 1'b0);
        chk("t1_digits_early", w_digits, 8'h00);
        cyc(1);
        chk("t1_tick1", w_tick, 1'b1);
        chk("t1_digits1", w_digits, 8'h01);
        cyc(1);
        chk("t1_tick_pulse", w_tick, 1'b0);
        cyc(3);
        chk("t1_digits2", w_digits, 8'h02);
        chk("t1_tick2", w_tick, 1'b1);

        // Wrap up and down; saturating copy stops at 99
        do_load(8'h98);
        chk("t2_load98", w_digits, 8'h98);
        cyc(4);
        chk("t2_w99", w_digits, 8'h99);
        chk("t2_w_tc0", w_tc, 1'b0);
        chk("t2_s99", s_digits, 8'h99);
        chk("t2_s_tc", s_tc, 1'b1);
        chk("t2_s_stop", s_running, 1'b0);
        cyc(4);
        chk("t2_wrap00", w_digits, 8'h00);
        chk("t2_wrap_tc", w_tc, 1'b1);
        cyc(1);
        chk("t2_tc_pulse", w_tc, 1'b0);
        up_dn = 1'b0;
        cyc(3);
        chk("t2_wrap99", w_digits, 8'h99);
        chk("t2_wrap_dn_tc", w_tc, 1'b1);

        // Saturate at 00 counting down
        do_clear();
        do_load(8'h01);
        chk("t3_load01", s_digits, 8'h01);
        chk("t3_load_no_run", s_running, 1'b0);
        pulse_ss();
        cyc(3);
        chk("t3_tc_early", s_tc, 1'b0);
        chk("t3_digits_early", s_digits, 8'h01);
        cyc(1);
        chk("t3_s00", s_digits, 8'h00);
        chk("t3_s_tc", s_tc, 1'b1);
        chk("t3_s_stop", s_running, 1'b0);
        chk("t3_w_tc0", w_tc, 1'b0);
        chk("t3_w_run", w_running, 1'b1);
        pulse_ss();
        chk("t3_restart", s_running, 1'b1);
        cyc(3);
        chk("t3_sat_tc_early", s_tc, 1'b0);
        cyc(1);
        chk("t3_sat_tc", s_tc, 1'b1);
        chk("t3_sat_tick", s_tick, 1'b1);
        chk("t3_sat_hold", s_digits, 8'h00);
        chk("t3_sat_run", s_running, 1'b1);

        // Lap freeze
        do_clear();
        up_dn = 1'b1;
        pulse_ss();
        cyc(20);
        chk("t4_digits05", w_digits, 8'h05);
        pulse_lap();
        chk("t4_frozen", w_display, 8'h05);
        chk("t4_hold", w_lap_hold, 1'b1);
        cyc(7);
        chk("t4_digits07", w_digits, 8'h07);
        chk("t4_still_frozen", w_display, 8'h05);
        pulse_lap();
        chk("t4_unfrozen", w_display, 8'h07);
        chk("t4_hold_off", w_lap_hold, 1'b0);

        // Clear beats start_stop; load clamps nibbles
        pulse_lap();
        cyc(1);
        clear      = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        clear      = 1'b0;
        start_stop = 1'b0;
        chk("t5_digits", w_digits, 8'h00);
        chk("t5_running", w_running, 1'b0);
        chk("t5_hold", w_lap_hold, 1'b0);
        chk("t5_display", w_display, 8'h00);
        cyc(5);
        chk("t5_stays_stopped", w_digits, 8'h00);
        do_load(8'hA3);
        chk("t5_clamp_hi", w_digits, 8'h93);
        chk("t5_clamp_disp", w_display, 8'h93);
        do_load(8'h5C);
        chk("t5_clamp_lo", w_digits, 8'h59);

        // Asynchronous reset mid-interval
        do_load(8'h42);
        pulse_ss();
        cyc(2);
        chk("t6_pre_reset", w_digits, 8'h42);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_digits", w_digits, 8'h00);
        chk("t6_async_display", w_display, 8'h00);
        chk("t6_async_running", w_running, 1'b0);
        cyc(2);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("t6_no_tick", w_tick, 1'b0);
        end
        chk("t6_digits_idle", w_digits, 8'h00);
        chk("t6_running_idle", w_running, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
